alu_share_arbiter: RTL and testbench

- Shares one combinational 3-bit ALU instance (8 ops: ADD, SUB, INC, AND, OR, XOR, 1's cmp, 2's cmp; flags V/N/C/Z) between NUM_REQ requesters.
- Each requester issues operations over a valid/ready handshake. The block picks one round-robin, registers its operands, drives the ALU, captures result and flags, and returns them on a single response channel tagged with the requester id.
- Sits between the requester front-ends and the shared ALU instance.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/rr_picker.sv | 30 +++
 rtl/alu_share_arbiter.sv | 138 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: opcodes, flag bundle and FSM states.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_CMP1 = 3'b110;
  localparam logic [2:0] OP_CMP2 = 3'b111;

  typedef struct packed {
    logic v;
    logic n;
    logic c;
    logic z;
  } alu_flags_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_req
);

  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any_req   = |req;
    // Walk from farthest to nearest so the candidate closest to ptr wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational 3-bit ALU between NUM_REQ requesters.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [3*NUM_REQ-1:0] req_a,
  input  logic [3*NUM_REQ-1:0] req_b,
  input  logic [3*NUM_REQ-1:0] req_sel,
  output logic [2:0]           alu_a,
  output logic [2:0]           alu_b,
  output logic [2:0]           alu_sel,
  input  logic [2:0]           alu_f,
  input  logic                 alu_v,
  input  logic                 alu_n,
  input  logic                 alu_c,
  input  logic                 alu_z,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [2:0]           rsp_f,
  output logic [3:0]           rsp_flags,
  output logic                 busy
);

  arb_state_t state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [2:0]      op_a_q, op_a_d;
  logic [2:0]      op_b_q, op_b_d;
  logic [2:0]      op_sel_q, op_sel_d;
  logic [2:0]      rsp_f_q, rsp_f_d;
  alu_flags_t      rsp_flags_q, rsp_flags_d;
  logic            rsp_valid_q, rsp_valid_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               any_req;
  logic               window;
  logic               accept;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // A new op may enter only when the response register is free or being drained this cycle.
  assign window    = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
  assign accept    = window && any_req;
  assign req_ready = window ? grant : '0;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_sel_d    = op_sel_q;
    rsp_id_d    = rsp_id_q;
    rsp_f_d     = rsp_f_q;
    rsp_flags_d = rsp_flags_q;
    rsp_valid_d = rsp_valid_q;

    if (accept) begin
      op_a_d   = req_a[int'(grant_idx)*3 +: 3];
      op_b_d   = req_b[int'(grant_idx)*3 +: 3];
      op_sel_d = req_sel[int'(grant_idx)*3 +: 3];
      id_d     = grant_idx;
      ptr_d    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      state_d  = EXEC;
    end

    case (state_q)
      EXEC: begin
        rsp_f_d     = alu_f;
        rsp_flags_d = '{v: alu_v, n: alu_n, c: alu_c, z: alu_z};
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!accept) state_d = IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_sel_q    <= '0;
      rsp_id_q    <= '0;
      rsp_f_q     <= '0;
      rsp_flags_q <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_sel_q    <= op_sel_d;
      rsp_id_q    <= rsp_id_d;
      rsp_f_q     <= rsp_f_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign alu_a     = op_a_q;
  assign alu_b     = op_b_q;
  assign alu_sel   = op_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_f     = rsp_f_q;
  assign rsp_flags = rsp_flags_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus randomized traffic vs a transaction model.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = $clog2(NUM_REQ);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [3*NUM_REQ-1:0] req_a, req_b, req_sel;
  logic [2:0]           alu_a, alu_b, alu_sel, alu_f;
  logic                 alu_v, alu_n, alu_c, alu_z;
  logic                 rsp_valid, rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [2:0]           rsp_f;
  logic [3:0]           rsp_flags;
  logic                 busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit auto_on   = 0;
  bit always_on = 0;
  logic [NUM_REQ-1:0] hs = '0;

  alu_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_f(alu_f), .alu_v(alu_v), .alu_n(alu_n), .alu_c(alu_c), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_f(rsp_f), .rsp_flags(rsp_flags), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the shared ALU; returns {f, v, n, c, z}.
  function automatic logic [6:0] alu_ref(input logic [2:0] a, input logic [2:0] b, input logic [2:0] s);
    logic [3:0] r;
    logic v;
    r = 4'd0;
    v = 1'b0;
    case (s)
      OP_ADD:  begin r = {1'b0, a} + {1'b0, b}; v = (a[2] == b[2]) && (r[2] != a[2]); end
      OP_SUB:  begin r = {1'b0, a} - {1'b0, b}; v = (a[2] != b[2]) && (r[2] != a[2]); end
      OP_INC:  begin r = {1'b0, a} + 4'd1;      v = (a == 3'b011); end
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_CMP1: r = {1'b0, ~a};
      default: begin r = 4'd0 - {1'b0, a}; v = (a == 3'b100); end
    endcase
    return {r[2:0], v, r[2], r[3], (r[2:0] == 3'b000)};
  endfunction

  always_comb {alu_f, alu_v, alu_n, alu_c, alu_z} = alu_ref(alu_a, alu_b, alu_sel);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] a, input logic [2:0] b, input logic [2:0] s);
    req_valid[i]       = v;
    req_a[3*i +: 3]    = a;
    req_b[3*i +: 3]    = b;
    req_sel[3*i +: 3]  = s;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_sel = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_reqs();
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Transaction model: at most one op in flight; its response becomes visible two cycles after acceptance.
  int         m_ptr = 0;
  bit         m_have = 0, m_seen = 0;
  int         m_due = 0;
  int         m_id = 0;
  logic [6:0] m_res = '0;
  logic [2:0] m_a = '0, m_b = '0, m_s = '0;

  always @(negedge clk) begin
    bit exp_valid, win;
    int g, idx;
    logic [NUM_REQ-1:0] exp_rdy;
    if (!rst_n) begin
      m_have = 0; m_seen = 0; m_ptr = 0; hs = '0;
    end else begin
      exp_valid = m_have && (cyc >= m_due);
      win = !m_have || (exp_valid && rsp_ready);
      g = -1;
      if (win) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = (m_ptr + k) % NUM_REQ;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("m_req_ready", req_ready, exp_rdy);
      check("m_rsp_valid", rsp_valid, exp_valid);
      check("m_busy", busy, m_have);
      check("m_alu_ops", {alu_a, alu_b, alu_sel}, m_seen ? {m_a, m_b, m_s} : 9'd0);
      if (exp_valid) begin
        check("m_rsp_id", rsp_id, m_id);
        check("m_rsp_f_flags", {rsp_f, rsp_flags}, m_res);
      end
      hs = req_valid & req_ready;
      if (exp_valid && rsp_ready) m_have = 0;
      if (g >= 0) begin
        m_a = req_a[3*g +: 3];
        m_b = req_b[3*g +: 3];
        m_s = req_sel[3*g +: 3];
        m_res = alu_ref(m_a, m_b, m_s);
        m_have = 1; m_seen = 1; m_id = g; m_due = cyc + 2;
        m_ptr = (g + 1) % NUM_REQ;
      end
    end
  end

  // Randomized requesters: hold payload until accepted, then maybe issue a fresh op.
  always @(posedge clk) begin
    #1;
    if (auto_on && rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] || hs[i]) begin
          if (always_on || $urandom_range(0, 2) != 0)
            set_req(i, 1'b1, 3'($urandom), 3'($urandom), 3'($urandom));
          else
            req_valid[i] = 1'b0;
        end
      end
    end
  end

  initial begin
    int nresp;
    do_reset();
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_regs", {rsp_id, rsp_f, rsp_flags}, '0);

    // Single AND op after reset.
    set_req(0, 1'b1, 3'b110, 3'b011, OP_AND);
    smp(); check("t1_ready", req_ready, 2'b01);
    next_cyc(); req_valid[0] = 1'b0;
    next_cyc(); smp();
    check("t1_rsp_valid", rsp_valid, 1'b1);
    check("t1_rsp", {rsp_id, rsp_f, rsp_flags}, {1'b0, 3'b010, 4'b0000});
    next_cyc(); smp();
    check("t1_idle", {rsp_valid, busy}, 2'b00);

    // Simultaneous requests from reset.
    do_reset();
    set_req(0, 1'b1, 3'b101, 3'b101, OP_XOR);
    set_req(1, 1'b1, 3'b100, 3'b001, OP_OR);
    smp(); check("t2_ready0", req_ready, 2'b01);
    next_cyc(); req_valid[0] = 1'b0;
    next_cyc(); smp();
    check("t2_rsp0", {rsp_valid, rsp_id, rsp_f, rsp_flags}, {1'b1, 1'b0, 3'b000, 4'b0001});
    check("t2_ready1", req_ready, 2'b10);
    next_cyc(); req_valid[1] = 1'b0;
    next_cyc(); smp();
    check("t2_rsp1", {rsp_valid, rsp_id, rsp_f, rsp_flags}, {1'b1, 1'b1, 3'b101, 4'b0100});

    // Back-pressure with req1 waiting.
    do_reset();
    set_req(0, 1'b1, 3'b001, 3'b001, OP_ADD);
    next_cyc();
    req_valid[0] = 1'b0;
    rsp_ready = 1'b0;
    set_req(1, 1'b1, 3'b011, 3'b001, OP_SUB);
    next_cyc();
    for (int c = 0; c < 5; c++) begin
      smp();
      check("bp_hold", {rsp_valid, rsp_id, rsp_f, rsp_flags, req_ready}, {1'b1, 1'b0, 3'b010, 4'b0000, 2'b00});
      next_cyc();
    end
    rsp_ready = 1'b1;
    smp(); check("bp_release_ready", req_ready, 2'b10);
    next_cyc(); req_valid[1] = 1'b0;
    smp(); check("bp_valid_drop", rsp_valid, 1'b0);
    next_cyc(); smp();
    check("bp_rsp1", {rsp_valid, rsp_id, rsp_f}, {1'b1, 1'b1, 3'b010});

    // Reset during EXEC of a req1 op, then during RESP.
    do_reset();
    set_req(1, 1'b1, 3'b010, 3'b001, OP_OR);
    smp(); check("rm_ready", req_ready, 2'b10);
    next_cyc();
    req_valid[1] = 1'b0;
    rst_n = 1'b0;
    #1 check("rm_exec_rst", {rsp_valid, busy}, 2'b00);
    do_reset();
    set_req(0, 1'b1, 3'b111, 3'b001, OP_ADD);
    next_cyc(); req_valid[0] = 1'b0; rsp_ready = 1'b0;
    next_cyc(); smp(); check("rm_resp_up", rsp_valid, 1'b1);
    next_cyc();
    rst_n = 1'b0;
    #1 check("rm_resp_rst", {rsp_valid, busy}, 2'b00);
    do_reset();
    for (int c = 0; c < 4; c++) begin
      smp(); check("rm_no_stale", rsp_valid, 1'b0);
      next_cyc();
    end
    set_req(0, 1'b1, 3'b001, 3'b010, OP_SUB);
    set_req(1, 1'b1, 3'b011, 3'b011, OP_XOR);
    smp(); check("rm_ptr_zero", req_ready, 2'b01);
    next_cyc(); clear_reqs();
    repeat (3) next_cyc();

    // Fairness: both permanently valid.
    do_reset();
    set_req(0, 1'b1, 3'($urandom), 3'($urandom), 3'($urandom));
    set_req(1, 1'b1, 3'($urandom), 3'($urandom), 3'($urandom));
    always_on = 1; auto_on = 1;
    nresp = 0;
    for (int c = 0; c < 18; c++) begin
      smp();
      if (rsp_valid && rsp_ready) begin
        check("fair_id", rsp_id, nresp % 2);
        nresp++;
      end
      @(posedge clk);
    end
    check("fair_count", nresp, 8);

    // Randomized traffic with random back-pressure.
    always_on = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1 rsp_ready = ($urandom_range(0, 3) != 0);
    end
    auto_on = 0;
    next_cyc();
    clear_reqs();
    rsp_ready = 1'b1;
    repeat (4) next_cyc();
    smp(); check("drain_idle", {rsp_valid, busy}, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
